stage_sequencer: RTL and testbench
==================================

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 SHALL have parameter MAP_COLS, 11, tiles per stage row.
REQ-002 SHALL have parameter MAP_ROWS, 11, tiles per stage column; N = MAP_COLS*MAP_ROWS, TW = clog2(N).
REQ-003 SHALL have parameter NUM_PLAYERS, 2, sprites drawn per frame; PW = max(1, clog2(NUM_PLAYERS)).
REQ-004 SHALL have parameter TICK_DIV, 833333, clock cycles per frame tick (60 Hz at 50 MHz).
REQ-005 SHALL have parameter FRAMES_PER_STEP, 15, frame ticks per game step.
REQ-006 SHALL have port clock  input  1  system clock, all state on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high.
REQ-008 SHALL have port go  input  1  user start/continue level.
REQ-009 SHALL have port finished  input  1  one-cycle pulse from draw datapath: current job done.
REQ-010 SHALL have port game_over  input  1  level from game logic: a player is dead.
REQ-011 SHALL have port memory_select  output  2  0 title, 1 stage background, 2 win screen, 3 tile/sprite ROM.
REQ-012 SHALL have port copy_enable  output  1  background copy request.
REQ-013 SHALL have port draw_tile  output  1  tile draw request.
REQ-014 SHALL have port tile_index  output  TW  map address of tile being drawn, row-major.
REQ-015 SHALL have port draw_player  output  1  sprite draw request.
REQ-016 SHALL have port player_sel  output  PW  index of sprite being drawn.
REQ-017 SHALL have port stage_init  output  1  one-cycle pulse: copy initial map into working map.
REQ-018 SHALL have port update_stage  output  1  one-cycle pulse: advance game logic one step.
REQ-019 SHALL have port state  output  4  current state encoding, for debug.

Function
REQ-020 SHALL implement states LOAD_TITLE=0, TITLE=1, LOAD_STAGE=2, DRAW_TILE=3, NEXT_TILE=4, DRAW_PLAYER=5, NEXT_PLAYER=6, GAME_IDLE=7, UPDATE_STAGE=8, LOAD_WIN=10, WIN=11, PAUSED=12; others -> LOAD_TITLE next cycle.
REQ-021 SHALL transition: LOAD_TITLE->TITLE, LOAD_STAGE->DRAW_TILE, LOAD_WIN->WIN, DRAW_TILE->NEXT_TILE, DRAW_PLAYER->NEXT_PLAYER, each on finished.
REQ-022 SHALL go TITLE->LOAD_STAGE and WIN->LOAD_TITLE only on a go rising edge (go high this cycle, low previous cycle); a held go advances at most one state.
REQ-023 SHALL in NEXT_TILE increment tile_index and return to DRAW_TILE, or, at tile_index=N-1, clear it to 0 and go to DRAW_PLAYER.
REQ-024 SHALL in NEXT_PLAYER increment player_sel and return to DRAW_PLAYER, or, at NUM_PLAYERS-1, clear it and go to GAME_IDLE.
REQ-025 SHALL on GAME_IDLE entry clear tick and frame counters; leave for UPDATE_STAGE exactly TICK_DIV*FRAMES_PER_STEP cycles after entry.
REQ-026 SHALL in UPDATE_STAGE pulse update_stage, then go to LOAD_WIN if game_over is high that cycle, else DRAW_TILE.
REQ-027 SHALL assert copy_enable with memory_select 0/1/2 in LOAD_TITLE/LOAD_STAGE/LOAD_WIN; memory_select 3 in DRAW_TILE, NEXT_TILE, DRAW_PLAYER, NEXT_PLAYER; 0 elsewhere.
REQ-028 SHALL assert draw_tile only in DRAW_TILE and draw_player only in DRAW_PLAYER; all outputs Moore (state-decoded).
REQ-029 SHALL pulse stage_init for the first cycle of LOAD_STAGE only.
REQ-030 SHALL ignore finished outside LOAD_*/DRAW_* states and game_over outside UPDATE_STAGE.
REQ-031 SHALL hold tile_index/player_sel when the state does not increment them.

Reset
REQ-032 SHALL on reset go to LOAD_TITLE; tile_index, player_sel, counters, go history = 0; update_stage, stage_init, draw_tile, draw_player = 0; copy_enable=1 and memory_select=0 per LOAD_TITLE.
REQ-033 SHALL abort any draw or count mid-operation on reset with no further pulses.

Configuration
REQ-034 SHALL with PAUSE_EN defined leave GAME_IDLE for PAUSED on a go rising edge, freezing counters; PAUSED returns to GAME_IDLE on next go rising edge, resuming counts.
REQ-035 SHALL without PAUSE_EN ignore go in GAME_IDLE, never reach PAUSED.

Verification
REQ-036 SHALL cover: reset then finished pulse -> TITLE; go held high 20 cycles -> LOAD_STAGE only, stage_init one pulse.
REQ-037 SHALL cover: MAP_COLS=MAP_ROWS=2, finished every DRAW_TILE -> tile_index 0,1,2,3 drawn, then player_sel 0,1, GAME_IDLE.
REQ-038 SHALL cover: TICK_DIV=4, FRAMES_PER_STEP=3 -> UPDATE_STAGE exactly 12 cycles after GAME_IDLE entry, update_stage 1 cycle.
REQ-039 SHALL cover: game_over=1 during UPDATE_STAGE -> LOAD_WIN, memory_select=2; finished then go edge -> LOAD_TITLE.
REQ-040 SHALL cover: reset asserted in DRAW_TILE at tile_index=5 -> LOAD_TITLE, tile_index=0 immediately.
REQ-041 SHALL cover (PAUSE_EN): go edge at cycle 5 of GAME_IDLE, 10 cycles paused, go edge -> UPDATE_STAGE 7 cycles after resume.

Source files
------------

// File: rtl/stage_sequencer.sv
// stage_sequencer: title/stage/win screen draw sequencer with frame-tick game stepping; define PAUSE_EN to allow pausing from GAME_IDLE.
module stage_sequencer #(
    parameter int MAP_COLS        = 11,
    parameter int MAP_ROWS        = 11,
    parameter int NUM_PLAYERS     = 2,
    parameter int TICK_DIV        = 833333,
    parameter int FRAMES_PER_STEP = 15,
    localparam int N  = MAP_COLS * MAP_ROWS,
    localparam int TW = (N > 1) ? $clog2(N) : 1,
    localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          go,
    input  logic          finished,
    input  logic          game_over,
    output logic [1:0]    memory_select,
    output logic          copy_enable,
    output logic          draw_tile,
    output logic [TW-1:0] tile_index,
    output logic          draw_player,
    output logic [PW-1:0] player_sel,
    output logic          stage_init,
    output logic          update_stage,
    output logic [3:0]    state
);
    localparam int KW = $clog2(TICK_DIV + 1);
    localparam int FW = $clog2(FRAMES_PER_STEP + 1);

    typedef enum logic [3:0] {
        LOAD_TITLE   = 4'd0,
        TITLE        = 4'd1,
        LOAD_STAGE   = 4'd2,
        DRAW_TILE    = 4'd3,
        NEXT_TILE    = 4'd4,
        DRAW_PLAYER  = 4'd5,
        NEXT_PLAYER  = 4'd6,
        GAME_IDLE    = 4'd7,
        UPDATE_STAGE = 4'd8,
        LOAD_WIN     = 4'd10,
        WIN          = 4'd11,
        PAUSED       = 4'd12
    } state_t;

    state_t        cur_state, next_state;
    logic          go_q;
    logic [KW-1:0] tick_count;
    logic [FW-1:0] frame_count;
    logic          go_rise, last_tile, last_player, step_done;
    logic          next_copy;
    logic [1:0]    next_select;

    assign state       = cur_state;
    assign go_rise     = go && !go_q;
    assign last_tile   = tile_index == TW'(N - 1);
    assign last_player = player_sel == PW'(NUM_PLAYERS - 1);
    assign step_done   = tick_count == KW'(TICK_DIV - 1) && frame_count == FW'(FRAMES_PER_STEP - 1);

    always_comb begin
        next_state = LOAD_TITLE;
        case (cur_state)
            LOAD_TITLE:   next_state = finished ? TITLE : LOAD_TITLE;
            TITLE:        next_state = go_rise ? LOAD_STAGE : TITLE;
            LOAD_STAGE:   next_state = finished ? DRAW_TILE : LOAD_STAGE;
            DRAW_TILE:    next_state = finished ? NEXT_TILE : DRAW_TILE;
            NEXT_TILE:    next_state = last_tile ? DRAW_PLAYER : DRAW_TILE;
            DRAW_PLAYER:  next_state = finished ? NEXT_PLAYER : DRAW_PLAYER;
            NEXT_PLAYER:  next_state = last_player ? GAME_IDLE : DRAW_PLAYER;
`ifdef PAUSE_EN
            GAME_IDLE:    next_state = go_rise ? PAUSED : step_done ? UPDATE_STAGE : GAME_IDLE;
            PAUSED:       next_state = go_rise ? GAME_IDLE : PAUSED;
`else
            GAME_IDLE:    next_state = step_done ? UPDATE_STAGE : GAME_IDLE;
`endif
            UPDATE_STAGE: next_state = game_over ? LOAD_WIN : DRAW_TILE;
            LOAD_WIN:     next_state = finished ? WIN : LOAD_WIN;
            WIN:          next_state = go_rise ? LOAD_TITLE : WIN;
            default:      next_state = LOAD_TITLE;
        endcase
    end

    assign next_copy   = next_state inside {LOAD_TITLE, LOAD_STAGE, LOAD_WIN};
    assign next_select = next_state == LOAD_STAGE ? 2'd1 :
                         next_state == LOAD_WIN ? 2'd2 :
                         next_state inside {DRAW_TILE, NEXT_TILE, DRAW_PLAYER, NEXT_PLAYER} ? 2'd3 : 2'd0;

    // Outputs are registered from the next-state decode, so they always match the state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_state     <= LOAD_TITLE;
            go_q          <= 1'b0;
            tick_count    <= '0;
            frame_count   <= '0;
            tile_index    <= '0;
            player_sel    <= '0;
            copy_enable   <= 1'b1;
            memory_select <= 2'd0;
            draw_tile     <= 1'b0;
            draw_player   <= 1'b0;
            stage_init    <= 1'b0;
            update_stage  <= 1'b0;
        end else begin
            cur_state     <= next_state;
            go_q          <= go;
            copy_enable   <= next_copy;
            memory_select <= next_select;
            draw_tile     <= next_state == DRAW_TILE;
            draw_player   <= next_state == DRAW_PLAYER;
            stage_init    <= next_state == LOAD_STAGE && cur_state != LOAD_STAGE;
            update_stage  <= next_state == UPDATE_STAGE;
            if (cur_state == NEXT_TILE)
                tile_index <= last_tile ? '0 : tile_index + 1'b1;
            if (cur_state == NEXT_PLAYER)
                player_sel <= last_player ? '0 : player_sel + 1'b1;
            // Counters run only while staying idle; a pause freezes them, any other state clears them.
            if (cur_state == GAME_IDLE && next_state == GAME_IDLE) begin
                tick_count  <= tick_count == KW'(TICK_DIV - 1) ? '0 : tick_count + 1'b1;
                frame_count <= tick_count == KW'(TICK_DIV - 1) ? frame_count + 1'b1 : frame_count;
            end else if (cur_state != GAME_IDLE && cur_state != PAUSED) begin
                tick_count  <= '0;
                frame_count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed checks of the stage sequencer on a 2x2 map (plus a 3x3 instance for mid-draw reset).
module tb_stage_sequencer;
    logic       clock, reset, go, finished, game_over;
    logic [1:0] memory_select;
    logic       copy_enable, draw_tile, draw_player, stage_init, update_stage;
    logic [1:0] tile_index;
    logic [0:0] player_sel;
    logic [3:0] state;
    logic       b_reset, b_finished;
    logic [1:0] b_memory_select;
    logic       b_copy_enable, b_draw_tile, b_draw_player, b_stage_init, b_update_stage;
    logic [3:0] b_tile_index;
    logic [0:0] b_player_sel;
    logic [3:0] b_state;
    int checks = 0;
    int errors = 0;
    int inits;

    stage_sequencer #(.MAP_COLS(2), .MAP_ROWS(2), .NUM_PLAYERS(2), .TICK_DIV(4), .FRAMES_PER_STEP(3)) dut (
        .clock(clock), .reset(reset), .go(go), .finished(finished), .game_over(game_over),
        .memory_select(memory_select), .copy_enable(copy_enable), .draw_tile(draw_tile),
        .tile_index(tile_index), .draw_player(draw_player), .player_sel(player_sel),
        .stage_init(stage_init), .update_stage(update_stage), .state(state)
    );

    stage_sequencer #(.MAP_COLS(3), .MAP_ROWS(3), .NUM_PLAYERS(2), .TICK_DIV(4), .FRAMES_PER_STEP(3)) dut_big (
        .clock(clock), .reset(b_reset), .go(go), .finished(b_finished), .game_over(game_over),
        .memory_select(b_memory_select), .copy_enable(b_copy_enable), .draw_tile(b_draw_tile),
        .tile_index(b_tile_index), .draw_player(b_draw_player), .player_sel(b_player_sel),
        .stage_init(b_stage_init), .update_stage(b_update_stage), .state(b_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_fin();
        finished = 1'b1;
        tick();
        finished = 1'b0;
    endtask

    task automatic pulse_b_fin();
        b_finished = 1'b1;
        tick();
        b_finished = 1'b0;
    endtask

    task automatic draw_frame();
        for (int i = 0; i < 4; i++) begin
            pulse_fin();
            tick();
        end
        for (int p = 0; p < 2; p++) begin
            pulse_fin();
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; b_reset = 1'b1; go = 1'b0; finished = 1'b0; b_finished = 1'b0; game_over = 1'b0;
        tick();
        tick();
        chk("reset_state", state, 0);
        chk("reset_copy", copy_enable, 1);
        chk("reset_select", memory_select, 0);
        chk("reset_tile", tile_index, 0);
        chk("reset_player", player_sel, 0);
        chk("reset_pulses", {update_stage, stage_init, draw_tile, draw_player}, 0);
        reset = 1'b0;
        tick();
        chk("title_wait", state, 0);
        pulse_fin();
        chk("title_state", state, 1);
        chk("title_copy", copy_enable, 0);
        // Held go: exactly one step to LOAD_STAGE and one stage_init pulse.
        go = 1'b1;
        inits = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            inits += int'(stage_init);
            chk("go_held_state", state, 2);
        end
        chk("stage_init_count", inits, 1);
        chk("load_stage_select", memory_select, 1);
        chk("load_stage_copy", copy_enable, 1);
        go = 1'b0;
        pulse_fin();
        for (int i = 0; i < 4; i++) begin
            chk("draw_tile_state", state, 3);
            chk("draw_tile_index", tile_index, i);
            chk("draw_tile_flag", draw_tile, 1);
            chk("draw_tile_select", memory_select, 3);
            pulse_fin();
            chk("next_tile_state", state, 4);
            chk("next_tile_flag", draw_tile, 0);
            tick();
            chk("after_next_tile", state, i < 3 ? 3 : 5);
            chk("after_next_index", tile_index, i < 3 ? i + 1 : 0);
        end
        for (int p = 0; p < 2; p++) begin
            chk("draw_player_state", state, 5);
            chk("draw_player_flag", draw_player, 1);
            chk("draw_player_sel", player_sel, p);
            pulse_fin();
            chk("next_player_state", state, 6);
            tick();
            chk("after_next_player", state, p < 1 ? 5 : 7);
            chk("after_next_sel", player_sel, p < 1 ? p + 1 : 0);
        end
        chk("idle_select", memory_select, 0);
        chk("idle_copy", copy_enable, 0);
`ifdef PAUSE_EN
        // Pause after 5 counted cycles, 10 paused cycles, then 7 more counted cycles.
        for (int i = 1; i <= 23; i++) begin
            go = (i == 6 || i == 16);
            finished = (i == 9);
            tick();
            chk("pause_idle_state", state, i < 6 ? 7 : i < 16 ? 12 : i < 23 ? 7 : 8);
        end
`else
        for (int i = 1; i <= 12; i++) begin
            go = (i == 4);
            finished = (i == 6);
            tick();
            chk("idle_state", state, i < 12 ? 7 : 8);
        end
`endif
        go = 1'b0;
        finished = 1'b0;
        chk("update_pulse", update_stage, 1);
        tick();
        chk("update_to_draw", state, 3);
        chk("update_pulse_end", update_stage, 0);
        chk("redraw_tile", tile_index, 0);
        draw_frame();
        chk("second_idle", state, 7);
        game_over = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("second_idle_state", state, i < 12 ? 7 : 8);
        end
        tick();
        game_over = 1'b0;
        chk("win_load_state", state, 10);
        chk("win_load_select", memory_select, 2);
        chk("win_load_copy", copy_enable, 1);
        go = 1'b1;
        tick();
        chk("win_load_hold", state, 10);
        pulse_fin();
        chk("win_state", state, 11);
        tick();
        chk("win_go_held", state, 11);
        go = 1'b0;
        tick();
        go = 1'b1;
        tick();
        chk("win_to_title", state, 0);
        chk("win_to_title_copy", copy_enable, 1);
        go = 1'b0;
        // Mid-draw asynchronous reset on the 3x3 instance.
        b_reset = 1'b0;
        tick();
        pulse_b_fin();
        chk("b_title", b_state, 1);
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("b_load_stage", b_state, 2);
        pulse_b_fin();
        for (int i = 0; i < 5; i++) begin
            pulse_b_fin();
            tick();
        end
        chk("b_draw_state", b_state, 3);
        chk("b_draw_index", b_tile_index, 5);
        #2;
        b_reset = 1'b1;
        #1;
        chk("b_async_state", b_state, 0);
        chk("b_async_index", b_tile_index, 0);
        chk("b_async_draw", b_draw_tile, 0);
        chk("b_async_copy", b_copy_enable, 1);
        b_finished = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("b_reset_quiet", {b_draw_tile, b_draw_player, b_stage_init, b_update_stage}, 0);
        end
        b_finished = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
